// File: rtl/cardinal_ppp_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : cardinal_ppp_regfile
//  Purpose  : NREG x DATA_W register file with two combinational read ports,
//             one ppp lane-masked write port and a per-register busy
//             scoreboard. Optional write-to-read bypass via RF_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module cardinal_ppp_regfile #(
    parameter int DATA_W = 64,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] addr_r1,
    input  logic [ADDR_W-1:0] addr_r2,
    output logic [0:DATA_W-1] data_r1,
    output logic [0:DATA_W-1] data_r2,
    input  logic              wr_en,
    input  logic [2:0]        ppp,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [0:DATA_W-1] in_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy_r1,
    output logic              busy_r2,
    output logic              ppp_err
);

    localparam int c_nbytes = DATA_W / 8;

    logic [0:DATA_W-1] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic              r_ppp_err;

    logic [0:DATA_W-1] w_mask;
    logic [0:DATA_W-1] w_wr_merged;
    logic [NREG-1:0]   w_busy_nxt;
    logic              w_illegal;
    logic [0:DATA_W-1] w_rd1_stored;
    logic [0:DATA_W-1] w_rd2_stored;

    function automatic logic [0:DATA_W-1] f_merge(
        input logic [0:DATA_W-1] old_v,
        input logic [0:DATA_W-1] new_v,
        input logic [0:DATA_W-1] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Byte 0 is the most significant byte; illegal codes select no lanes.
    for (genvar k = 0; k < c_nbytes; k++) begin : g_lane
        localparam bit c_upper = (k < c_nbytes / 2);
        localparam bit c_even  = ((k % 2) == 0);
        logic w_sel;

        always_comb begin
            case (ppp)
                3'b000:  w_sel = 1'b1;
                3'b001:  w_sel = c_upper;
                3'b010:  w_sel = !c_upper;
                3'b011:  w_sel = c_even;
                3'b100:  w_sel = !c_even;
                default: w_sel = 1'b0;
            endcase
        end

        assign w_mask[8*k +: 8] = {8{w_sel}};
    end

    assign w_illegal   = (ppp > 3'b100);
    assign w_wr_merged = f_merge(r_regs[in_addr], in_data, w_mask);

    // Set is applied after clear so a same-cycle issue wins over writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wr_en) begin
            w_busy_nxt[in_addr] = 1'b0;
        end
        if (issue_en) begin
            w_busy_nxt[issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && (in_addr != '0)) begin
            r_regs[in_addr] <= w_wr_merged;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_busy    <= '0;
            r_ppp_err <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_ppp_err <= wr_en && w_illegal;
        end
    end

    assign ppp_err      = r_ppp_err;
    assign w_rd1_stored = (addr_r1 == '0) ? '0 : r_regs[addr_r1];
    assign w_rd2_stored = (addr_r2 == '0) ? '0 : r_regs[addr_r2];

`ifdef RF_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = wr_en && !Reset && (addr_r1 != '0) && (in_addr == addr_r1);
    assign w_hit2 = wr_en && !Reset && (addr_r2 != '0) && (in_addr == addr_r2);

    // A same-cycle issue to the bypassed register keeps its busy visible.
    always_comb begin
        data_r1 = w_rd1_stored;
        busy_r1 = (addr_r1 != '0) && r_busy[addr_r1];
        if (w_hit1) begin
            data_r1 = f_merge(w_rd1_stored, in_data, w_mask);
            if (!(issue_en && (issue_addr == addr_r1))) begin
                busy_r1 = 1'b0;
            end
        end
    end

    always_comb begin
        data_r2 = w_rd2_stored;
        busy_r2 = (addr_r2 != '0) && r_busy[addr_r2];
        if (w_hit2) begin
            data_r2 = f_merge(w_rd2_stored, in_data, w_mask);
            if (!(issue_en && (issue_addr == addr_r2))) begin
                busy_r2 = 1'b0;
            end
        end
    end
`else
    always_comb begin
        data_r1 = w_rd1_stored;
        busy_r1 = (addr_r1 != '0) && r_busy[addr_r1];
    end

    always_comb begin
        data_r2 = w_rd2_stored;
        busy_r2 = (addr_r2 != '0) && r_busy[addr_r2];
    end
`endif

endmodule
`default_nettype wire
